// File: rtl/alu_issue_pkg.sv
// Shared types, command codes, flag indices and operand/latency decode for the ALU issuer.
package alu_issue_pkg;

  // Wide enough for the clamped gap and the command latencies.
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {IDLE, BEAT_A, GAP, BEAT_B, WAIT, RESP} state_t;

  // Arithmetic commands (MODE=1)
  localparam logic [3:0] CMD_ADD     = 4'd0;
  localparam logic [3:0] CMD_INC_A   = 4'd4;
  localparam logic [3:0] CMD_DEC_A   = 4'd5;
  localparam logic [3:0] CMD_INC_B   = 4'd6;
  localparam logic [3:0] CMD_DEC_B   = 4'd7;
  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Logical commands (MODE=0)
  localparam logic [3:0] CMD_NOT_A   = 4'd6;
  localparam logic [3:0] CMD_NOT_B   = 4'd7;
  localparam logic [3:0] CMD_SHR1_A  = 4'd8;
  localparam logic [3:0] CMD_SHL1_A  = 4'd9;
  localparam logic [3:0] CMD_SHR1_B  = 4'd10;
  localparam logic [3:0] CMD_SHL1_B  = 4'd11;

  // Bit positions inside {ERR,OFLOW,COUT,G,L,E}
  localparam int unsigned FLAG_E     = 0;
  localparam int unsigned FLAG_L     = 1;
  localparam int unsigned FLAG_G     = 2;
  localparam int unsigned FLAG_COUT  = 3;
  localparam int unsigned FLAG_OFLOW = 4;
  localparam int unsigned FLAG_ERR   = 5;

  localparam logic [1:0] NEED_A  = 2'b01;
  localparam logic [1:0] NEED_B  = 2'b10;
  localparam logic [1:0] NEED_AB = 2'b11;

  // Which operands the ALU consumes for a command: bit0 = A, bit1 = B.
  function automatic logic [1:0] op_needs(input logic mode, input logic [3:0] cmd);
    logic [1:0] need;
    need = NEED_AB;
    if (mode) begin
      if (cmd == CMD_INC_A || cmd == CMD_DEC_A) need = NEED_A;
      else if (cmd == CMD_INC_B || cmd == CMD_DEC_B) need = NEED_B;
    end else begin
      if (cmd == CMD_NOT_A || cmd == CMD_SHR1_A || cmd == CMD_SHL1_A) need = NEED_A;
      else if (cmd == CMD_NOT_B || cmd == CMD_SHR1_B || cmd == CMD_SHL1_B) need = NEED_B;
    end
    return need;
  endfunction

  // Cycles from the final beat until RES is valid; the multipliers take longer.
  function automatic logic [CNT_W-1:0] op_latency(input logic mode, input logic [3:0] cmd,
                                                  input logic [CNT_W-1:0] res_lat,
                                                  input logic [CNT_W-1:0] mul_lat);
    if (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) return mul_lat;
    return res_lat;
  endfunction

endpackage

// File: rtl/alu_issue_lat_cnt.sv
// Loadable down-counter shared by the GAP and WAIT phases; flags when it sits at zero.
module alu_issue_lat_cnt
  import alu_issue_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_op_issuer.sv
// ALU operation issuer: takes one request, drives the ALU input side in one or two beats,
// captures RES/flags after the command latency and returns them on a response handshake.
// Optional build macro ALU_ISSUE_STATS_EN adds saturating stat_ops/stat_errs counters.
// CW must be at least 4; only the low four CMD bits are decoded.
module alu_op_issuer
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned RES_LAT = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [CW-1:0]   req_cmd,
  input  logic [DW-1:0]   req_opa,
  input  logic [DW-1:0]   req_opb,
  input  logic            req_cin,
  input  logic            req_split,
  input  logic [3:0]      req_gap,
  output logic [1:0]      INP_VALID,
  output logic            MODE,
  output logic [CW-1:0]   CMD,
  output logic            CE,
  output logic [DW-1:0]   OPA,
  output logic [DW-1:0]   OPB,
  output logic            CIN,
  input  logic [2*DW-1:0] RES,
  input  logic            ERR,
  input  logic            OFLOW,
  input  logic            COUT,
  input  logic            G,
  input  logic            L,
  input  logic            E,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_res,
  output logic [5:0]      rsp_flags
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]     stat_ops,
  output logic [15:0]     stat_errs
`endif
);

  // Gap is kept below the ALU's second-operand timeout.
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(TIMEOUT - 2);

  state_t                state_q, state_d;
  logic                  mode_q, cin_q, split_q;
  logic [CW-1:0]         cmd_q;
  logic [DW-1:0]         opa_q, opb_q;
  logic [1:0]            need_q;
  logic [CNT_W-1:0]      gap_q, lat_q, gap_clamped;
  logic [2*DW-1:0]       res_q;
  logic [5:0]            flags_q;
  logic                  idle_ready, accept, capture;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]      cnt_val;

  assign req_ready   = idle_ready & RST;
  assign accept      = req_valid & req_ready;
  assign gap_clamped = ({1'b0, req_gap} > GAP_MAX) ? GAP_MAX : {1'b0, req_gap};

  // State plus the request fields and the captured result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cmd_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      split_q <= 1'b0;
      need_q  <= '0;
      gap_q   <= '0;
      lat_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q  <= req_mode;
        cmd_q   <= req_cmd;
        opa_q   <= req_opa;
        opb_q   <= req_opb;
        cin_q   <= req_cin;
        split_q <= req_split;
        need_q  <= op_needs(req_mode, req_cmd[3:0]);
        lat_q   <= op_latency(req_mode, req_cmd[3:0], CNT_W'(RES_LAT), CNT_W'(MUL_LAT));
        gap_q   <= gap_clamped;
      end
      if (capture) begin
        res_q   <= RES;
        flags_q <= {ERR, OFLOW, COUT, G, L, E};
      end
    end
  end

  // Next state, beat qualifiers and counter control.
  always_comb begin
    state_d    = state_q;
    idle_ready = 1'b0;
    rsp_valid  = 1'b0;
    INP_VALID  = 2'b00;
    CE         = 1'b0;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_ready = 1'b1;
        if (req_valid) state_d = BEAT_A;
      end
      BEAT_A: begin
        CE = 1'b1;
        if (need_q == NEED_AB && split_q) begin
          INP_VALID = 2'b01;
          if (gap_q == '0) begin
            state_d = BEAT_B;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = gap_q - CNT_W'(1);
            state_d  = GAP;
          end
        end else begin
          INP_VALID = need_q;
          cnt_load  = 1'b1;
          cnt_val   = lat_q - CNT_W'(1);
          state_d   = WAIT;
        end
      end
      GAP: begin
        CE = 1'b1;
        if (cnt_zero) state_d = BEAT_B;
        else cnt_dec = 1'b1;
      end
      BEAT_B: begin
        CE        = 1'b1;
        INP_VALID = 2'b10;
        cnt_load  = 1'b1;
        cnt_val   = lat_q - CNT_W'(1);
        state_d   = WAIT;
      end
      WAIT: begin
        CE = 1'b1;
        // Last WAIT cycle: RES is valid, sample it on this edge.
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  alu_issue_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign MODE      = mode_q;
  assign CMD       = cmd_q;
  assign OPA       = opa_q;
  assign OPB       = opb_q;
  assign CIN       = cin_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_errs_q;
  logic        rsp_fire;

  assign rsp_fire = rsp_valid & rsp_ready;

  // Saturating counts of completed responses and of those reporting ERR.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
    end else if (rsp_fire) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (flags_q[FLAG_ERR] && stat_errs_q != 16'hFFFF) stat_errs_q <= stat_errs_q + 16'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer with a small behavioural ALU on the other side.
module tb_alu_op_issuer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid, req_ready, req_mode, req_cin, req_split;
  logic [3:0]  req_cmd, req_gap;
  logic [7:0]  req_opa, req_opb;
  logic [1:0]  INP_VALID;
  logic        MODE, CE, CIN;
  logic [3:0]  CMD;
  logic [7:0]  OPA, OPB;
  logic [15:0] RES;
  logic        ERR, OFLOW, COUT, G, L, E;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_res;
  logic [5:0]  rsp_flags;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_op_issuer dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_cmd   (req_cmd),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .req_cin   (req_cin),
    .req_split (req_split),
    .req_gap   (req_gap),
    .INP_VALID (INP_VALID),
    .MODE      (MODE),
    .CMD       (CMD),
    .CE        (CE),
    .OPA       (OPA),
    .OPB       (OPB),
    .CIN       (CIN),
    .RES       (RES),
    .ERR       (ERR),
    .OFLOW     (OFLOW),
    .COUT      (COUT),
    .G         (G),
    .L         (L),
    .E         (E),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_flags (rsp_flags)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
`endif
  );

  // Behavioural ALU: result {flags,res} for the handful of commands used here.
  function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    logic [5:0]  f;
    r = '0;
    f = '0;
    if (m) begin
      case (c)
        4'd0:    begin r = {7'b0, {1'b0, a} + {1'b0, b}}; f[3] = r[8]; end
        4'd9:    r = ({8'b0, a} + 16'd1) * ({8'b0, b} + 16'd1);
        4'd13:   f[5] = 1'b1;
        default: r = '0;
      endcase
    end else if (c == 4'd6) begin
      r = {8'h00, ~a};
    end
    return {f, r};
  endfunction

  // RES is valid for exactly one cycle at the expected latency, garbage otherwise.
  logic [1:0]  tb_need;
  logic [7:0]  a_l, b_l;
  logic        pipe_v = 1'b0;
  logic [21:0] pipe_r, alu_out;

  always @(posedge CLK) begin
    alu_out <= {6'h3F, 16'hDEAD};
    pipe_v  <= 1'b0;
    if (pipe_v) alu_out <= pipe_r;
    if (CE && INP_VALID[0]) a_l <= OPA;
    if (CE && INP_VALID[1]) b_l <= OPB;
    if (CE && (INP_VALID[1] || (INP_VALID == 2'b01 && tb_need == 2'b01))) begin
      if (MODE && (CMD == 4'd9 || CMD == 4'd10)) begin
        pipe_v <= 1'b1;
        pipe_r <= alu_fn(MODE, CMD, INP_VALID[0] ? OPA : a_l, INP_VALID[1] ? OPB : b_l);
      end else begin
        alu_out <= alu_fn(MODE, CMD, INP_VALID[0] ? OPA : a_l, INP_VALID[1] ? OPB : b_l);
      end
    end
  end

  assign RES = alu_out[15:0];
  assign {ERR, OFLOW, COUT, G, L, E} = alu_out[21:16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it until rsp_valid, checking the beat trace and the result.
  task automatic run_op(input string name, input logic m, input logic [3:0] c,
                        input logic [7:0] a, input logic [7:0] b, input logic split,
                        input logic [3:0] gap, input logic [1:0] need,
                        input logic [15:0] exp_res, input logic [5:0] exp_flags,
                        input logic [63:0] exp_trace, input int exp_len);
    logic [63:0] tr;
    int          len;
    logic        ce_all;
    @(negedge CLK);
    check($sformatf("%s_req_ready", name), {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_mode = m; req_cmd = c; req_opa = a; req_opb = b;
    req_cin = 1'b0; req_split = split; req_gap = gap; tb_need = need;
    @(posedge CLK); #1;
    req_valid = 1'b0; req_cmd = 4'hF; req_opa = 8'h5A; req_opb = 8'hA5; req_split = 1'b0;
    tr = '0; len = 0; ce_all = 1'b1;
    while (!rsp_valid && len < 40) begin
      @(negedge CLK);
      if (!rsp_valid) begin
        tr = {tr[61:0], INP_VALID};
        ce_all &= CE;
        len++;
      end
    end
    check($sformatf("%s_rsp_valid", name), {63'b0, rsp_valid}, 64'd1);
    check($sformatf("%s_trace", name), tr, exp_trace);
    check($sformatf("%s_cycles", name), 64'(len), 64'(exp_len));
    check($sformatf("%s_ce_busy", name), {63'b0, ce_all}, 64'd1);
    check($sformatf("%s_ce_resp", name), {63'b0, CE}, 64'd0);
    check($sformatf("%s_res", name), {48'b0, rsp_res}, {48'b0, exp_res});
    check($sformatf("%s_flags", name), {58'b0, rsp_flags}, {58'b0, exp_flags});
  endtask

  // Let the response handshake complete and confirm the issuer is ready again.
  task automatic finish_rsp(input string name);
    rsp_ready = 1'b1;
    @(negedge CLK);
    check($sformatf("%s_rsp_drop", name), {63'b0, rsp_valid}, 64'd0);
    check($sformatf("%s_rdy_back", name), {63'b0, req_ready}, 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return {15'b0, INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, req_ready, rsp_valid,
            rsp_res, rsp_flags};
  endfunction

  initial begin
    logic [15:0] res0;
    logic [5:0]  fl0;
    logic        stable;
    int          rsp_seen;
    RST = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_cmd = '0; req_opa = '0; req_opb = '0;
    req_cin = 1'b0; req_split = 1'b0; req_gap = '0; rsp_ready = 1'b1; tb_need = 2'b11;
    a_l = '0; b_l = '0; pipe_r = '0;
    repeat (3) @(negedge CLK);
    check("reset_outs", all_outs(), 64'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_ready", {63'b0, req_ready}, 64'd1);
    check("idle_ce", {63'b0, CE}, 64'd0);

    run_op("add", 1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 4'd0, 2'b11,
           16'h0010, 6'b000000, 64'hC, 2);
    finish_rsp("add");
    run_op("split", 1'b1, 4'd0, 8'hFF, 8'h01, 1'b1, 4'd3, 2'b11,
           16'h0100, 6'b001000, 64'h408, 6);
    finish_rsp("split");
    run_op("clamp", 1'b1, 4'd0, 8'h10, 8'h20, 1'b1, 4'd15, 2'b11,
           16'h0030, 6'b000000, 64'h1_0000_0008, 17);
    finish_rsp("clamp");
    run_op("mul", 1'b1, 4'd9, 8'h02, 8'h03, 1'b0, 4'd0, 2'b11,
           16'h000C, 6'b000000, 64'h30, 3);
    finish_rsp("mul");

    rsp_ready = 1'b0;
    run_op("not_a", 1'b0, 4'd6, 8'h0F, 8'h77, 1'b0, 4'd0, 2'b01,
           16'h00F0, 6'b000000, 64'h4, 2);
    res0 = rsp_res; fl0 = rsp_flags; stable = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      stable &= rsp_valid & ~req_ready & (rsp_res == res0) & (rsp_flags == fl0);
    end
    check("backpressure_hold", {63'b0, stable}, 64'd1);
    finish_rsp("not_a");

    run_op("err", 1'b1, 4'd13, 8'h01, 8'h02, 1'b0, 4'd0, 2'b11,
           16'h0000, 6'b100000, 64'hC, 2);
    finish_rsp("err");
`ifdef ALU_ISSUE_STATS_EN
    check("stat_ops", {48'b0, stat_ops}, 64'd6);
    check("stat_errs", {48'b0, stat_errs}, 64'd1);
`endif

    // Reset in the middle of a split transfer's GAP phase.
    @(negedge CLK);
    req_valid = 1'b1; req_mode = 1'b1; req_cmd = 4'd0; req_opa = 8'h11; req_opb = 8'h22;
    req_split = 1'b1; req_gap = 4'd5; tb_need = 2'b11;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("gap_before_rst", {62'b0, INP_VALID}, 64'd0);
    check("gap_ce_before_rst", {63'b0, CE}, 64'd1);
    #2 RST = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'd0);
`ifdef ALU_ISSUE_STATS_EN
    check("rst_stat_ops", {48'b0, stat_ops}, 64'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (rsp_valid) rsp_seen++;
    end
    check("no_rsp_after_rst", 64'(rsp_seen), 64'd0);

    run_op("post_rst", 1'b1, 4'd0, 8'h33, 8'h44, 1'b0, 4'd0, 2'b11,
           16'h0077, 6'b000000, 64'hC, 2);
    finish_rsp("post_rst");
`ifdef ALU_ISSUE_STATS_EN
    check("stat_ops_post", {48'b0, stat_ops}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
